// File: rtl/chg_event_log.sv
// chg_event_log -- per-channel change detector feeding a timestamped event FIFO.
//
// Each of NCH channels of width W is compared against its registered copy.
// A change updates the copy (o), flips the channel toggle bit (tog) and parks
// {value, stamp} in a one-deep pending slot for that channel. One pending
// channel per cycle is moved into the event FIFO, lowest index first. A second
// change on a channel whose slot is still occupied overwrites the slot and sets
// the sticky ovf flag.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   i[NCH*W]           monitored channels, channel c = i[c*W +: W]
//   o[NCH*W]           registered copy of i
//   tog[NCH]           per-channel toggle, flips on each detected change
//   ev_valid/ev_ready  FIFO head handshake
//   ev_ch/data/stamp   head event fields (combinational from storage)
//   level              FIFO occupancy, 0..DEPTH
//   ovf                sticky: an event was coalesced
//   tot_cnt            saturating count of pushed events

// Per-channel slice: registered copy, toggle bit and the pending slot.
module chg_event_log_lane #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prime_i,   // first cycle after reset: load only
  input  logic [W-1:0]  din_i,
  input  logic [15:0]   stamp_i,
  input  logic          take_i,    // pending slot moves into the FIFO this edge
  output logic [W-1:0]  o_o,
  output logic          tog_o,
  output logic          pend_o,
  output logic [W-1:0]  pval_o,
  output logic [15:0]   pstamp_o,
  output logic          coal_o     // change lands on a slot that stays occupied
);
  logic [W-1:0] o_q, pval_q;
  logic [15:0]  pstamp_q;
  logic         tog_q, pend_q;
  logic         chg;

  assign chg    = !prime_i && (din_i != o_q);
  // A slot drained on this same edge is free, so a re-change then is not a
  // coalesce: the old values go to the FIFO and the new ones take the slot.
  assign coal_o = chg && pend_q && !take_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q      <= '0;
      tog_q    <= 1'b0;
      pend_q   <= 1'b0;
      pval_q   <= '0;
      pstamp_q <= '0;
    end else begin
      if (prime_i || chg) o_q <= din_i;
      if (chg) begin
        tog_q    <= ~tog_q;
        pval_q   <= din_i;
        pstamp_q <= stamp_i;
      end
      pend_q <= chg | (pend_q & ~take_i);
    end
  end

  assign o_o      = o_q;
  assign tog_o    = tog_q;
  assign pend_o   = pend_q;
  assign pval_o   = pval_q;
  assign pstamp_o = pstamp_q;
endmodule

module chg_event_log #(
  parameter int NCH     = 4,
  parameter int W       = 8,
  parameter int DEPTH   = 8,
  parameter int VERBOSE = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NCH*W-1:0]                     i,
  output logic [NCH*W-1:0]                     o,
  output logic [NCH-1:0]                       tog,
  output logic                                 ev_valid,
  input  logic                                 ev_ready,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ev_ch,
  output logic [W-1:0]                         ev_data,
  output logic [15:0]                          ev_stamp,
  output logic [$clog2(DEPTH):0]               level,
  output logic                                 ovf,
  output logic [15:0]                          tot_cnt
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  data;
    logic [15:0]   stamp;
  } ev_t;

  // ---------------------------------------------------------------- state
  logic [15:0]   stamp_q, stamp_d;
  logic          prime_q;
  logic          ovf_q, ovf_d;
  logic [15:0]   tot_q, tot_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  ev_t           mem_q [DEPTH];

  // ---------------------------------------------------------------- lanes
  logic [NCH-1:0][W-1:0]  o_w, pval_w;
  logic [NCH-1:0][15:0]   pstamp_w;
  logic [NCH-1:0]         tog_w, pend_w, take_w, coal_w;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    chg_event_log_lane #(.W(W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .prime_i  (prime_q),
      .din_i    (i[c*W +: W]),
      .stamp_i  (stamp_q),
      .take_i   (take_w[c]),
      .o_o      (o_w[c]),
      .tog_o    (tog_w[c]),
      .pend_o   (pend_w[c]),
      .pval_o   (pval_w[c]),
      .pstamp_o (pstamp_w[c]),
      .coal_o   (coal_w[c])
    );
  end

  // ------------------------------------------------------ push arbitration
  logic [CW-1:0] sel_ch;
  logic          any_pend, full, push, pop;
  ev_t           wr_ev, head;

  // Scan high-to-low so the lowest pending index is the last to win.
  always_comb begin
    sel_ch   = '0;
    any_pend = 1'b0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (pend_w[c]) begin
        sel_ch   = CW'(c);
        any_pend = 1'b1;
      end
    end
  end

  assign pop   = (level_q != '0) && ev_ready;
  assign full  = (level_q == LW'(DEPTH));
  // A pop frees the slot at the same edge, so a full FIFO still accepts.
  assign push  = any_pend && (!full || pop);
  assign take_w = push ? (NCH'(1) << sel_ch) : '0;

  always_comb begin
    wr_ev       = '0;
    wr_ev.ch    = sel_ch;
    wr_ev.data  = pval_w[sel_ch];
    wr_ev.stamp = pstamp_w[sel_ch];
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    stamp_d  = stamp_q + 16'd1;
    ovf_d    = ovf_q | (|coal_w);
    tot_d    = tot_q;
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && tot_q != 16'hFFFF) tot_d = tot_q + 16'd1;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  // Storage is cleared on reset so the head fields read zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stamp_q  <= '0;
      prime_q  <= 1'b1;
      ovf_q    <= 1'b0;
      tot_q    <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      stamp_q  <= stamp_d;
      prime_q  <= 1'b0;
      ovf_q    <= ovf_d;
      tot_q    <= tot_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= wr_ev;
    end
  end

  // Optional simulation trace of each push; synthesis ignores $display.
  if (VERBOSE != 0) begin : g_verbose
    always @(posedge clk) begin
      if (rst_n && push)
        $display("chg_event_log: push ch=%0d data=%0h stamp=%0d",
                 wr_ev.ch, wr_ev.data, wr_ev.stamp);
    end
  end

  // --------------------------------------------------------------- outputs
  assign head     = mem_q[rd_ptr_q];
  assign o        = o_w;
  assign tog      = tog_w;
  assign ev_valid = (level_q != '0);
  assign ev_ch    = head.ch;
  assign ev_data  = head.data;
  assign ev_stamp = head.stamp;
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign tot_cnt  = tot_q;
endmodule

// File: tb/tb_chg_event_log.sv
module tb_chg_event_log;
  localparam int NCH = 4, W = 8, DEPTH = 8, CW = 2, LW = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH*W-1:0] din_s = '0;
  logic             ev_ready = 1'b0;
  logic [NCH*W-1:0] o_s;
  logic [NCH-1:0]   tog_s;
  logic             ev_valid;
  logic [CW-1:0]    ev_ch;
  logic [W-1:0]     ev_data;
  logic [15:0]      ev_stamp;
  logic [LW-1:0]    level;
  logic             ovf;
  logic [15:0]      tot_cnt;

  chg_event_log #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .VERBOSE(0)) dut (
    .clk(clk), .rst_n(rst_n), .i(din_s), .o(o_s), .tog(tog_s),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch),
    .ev_data(ev_data), .ev_stamp(ev_stamp), .level(level),
    .ovf(ovf), .tot_cnt(tot_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int edges = 0;  // rising edges since reset release

  // Reference model: channel copies, pending slots, event queue.
  logic [W-1:0]   m_o [NCH];
  logic [W-1:0]   m_pval [NCH];
  logic [15:0]    m_pstamp [NCH];
  bit             m_pend [NCH];
  logic [NCH-1:0] m_tog;
  bit             m_prime, m_ovf;
  logic [15:0]    m_tot, m_stamp;
  int             qc [$];
  logic [W-1:0]   qd [$];
  logic [15:0]    qs [$];

  // Drive one cycle of inputs and advance the model across the edge.
  task automatic tick(input logic [NCH*W-1:0] din, input logic rdy, input logic rstn);
    int pc;
    bit popd;
    din_s = din; ev_ready = rdy; rst_n = rstn;
    @(posedge clk);
    if (!rstn) begin
      edges = 0;
      for (int c = 0; c < NCH; c++) begin
        m_o[c] = '0; m_pval[c] = '0; m_pstamp[c] = '0; m_pend[c] = 0;
      end
      m_tog = '0; m_prime = 1; m_ovf = 0; m_tot = '0; m_stamp = '0;
      qc.delete(); qd.delete(); qs.delete();
    end else begin
      edges++;
      popd = (qc.size() != 0) && rdy;
      pc = -1;
      if (qc.size() < DEPTH || popd)
        for (int c = 0; c < NCH; c++) if (m_pend[c] && pc < 0) pc = c;
      if (popd) begin
        void'(qc.pop_front()); void'(qd.pop_front()); void'(qs.pop_front());
      end
      if (pc >= 0) begin
        qc.push_back(pc); qd.push_back(m_pval[pc]); qs.push_back(m_pstamp[pc]);
        m_pend[pc] = 0;
        if (m_tot != 16'hFFFF) m_tot = m_tot + 16'd1;
      end
      for (int c = 0; c < NCH; c++) begin
        logic [W-1:0] v;
        v = din[c*W +: W];
        if (m_prime) m_o[c] = v;
        else if (v != m_o[c]) begin
          if (m_pend[c]) m_ovf = 1;
          m_pend[c] = 1; m_pval[c] = v; m_pstamp[c] = m_stamp;
          m_o[c] = v; m_tog[c] = ~m_tog[c];
        end
      end
      m_prime = 0;
      m_stamp = m_stamp + 16'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(NCH*W'($urandom), 1'b1, 1'b0);
    tick(NCH*W'($urandom), 1'b0, 1'b0);
    total++; if (o_s !== '0) begin bad++; $display("FAIL reset_o: got %0h want 0", o_s); end
    total++; if (tog_s !== '0) begin bad++; $display("FAIL reset_tog: got %0h want 0", tog_s); end
    total++; if (ev_valid !== 1'b0 || level !== '0) begin bad++;
      $display("FAIL reset_fifo: valid=%0b level=%0d want 0/0", ev_valid, level); end
    total++; if (ovf !== 1'b0 || tot_cnt !== '0) begin bad++;
      $display("FAIL reset_flags: ovf=%0b tot=%0d want 0/0", ovf, tot_cnt); end
    total++; if ({ev_ch, ev_data, ev_stamp} !== '0) begin bad++;
      $display("FAIL reset_head: got %0h want 0", {ev_ch, ev_data, ev_stamp}); end
    // Release with a nonzero value held: loaded, not reported.
    tick(32'h12345678, 1'b0, 1'b1);
    total++; if (o_s !== 32'h12345678) begin bad++;
      $display("FAIL prime_o: got %0h want 12345678", o_s); end
    for (int n = 0; n < 3; n++) tick(32'h12345678, 1'b0, 1'b1);
    total++; if (ev_valid !== 1'b0 || tog_s !== '0 || level !== '0) begin bad++;
      $display("FAIL prime_noevent: valid=%0b tog=%0h level=%0d want 0/0/0", ev_valid, tog_s, level); end
  endtask

  task automatic test_single_change();
    logic [15:0] es;
    es = 16'(edges);
    tick(32'h12555678, 1'b1, 1'b1);
    total++; if (o_s !== 32'h12555678 || tog_s !== 4'b0100) begin bad++;
      $display("FAIL single_o_tog: o=%0h tog=%0h want 12555678/4", o_s, tog_s); end
    total++; if (ev_valid !== 1'b0) begin bad++;
      $display("FAIL single_latency: valid=%0b want 0", ev_valid); end
    tick(32'h12555678, 1'b1, 1'b1);
    total++; if (ev_valid !== 1'b1 || ev_ch !== 2'd2 || ev_data !== 8'h55 || ev_stamp !== es) begin bad++;
      $display("FAIL single_event: v=%0b ch=%0d d=%0h s=%0d want 1/2/55/%0d", ev_valid, ev_ch, ev_data, ev_stamp, es); end
    total++; if (tot_cnt !== 16'd1) begin bad++;
      $display("FAIL single_tot: got %0d want 1", tot_cnt); end
    tick(32'h12555678, 1'b1, 1'b1);
    total++; if (ev_valid !== 1'b0 || level !== '0) begin bad++;
      $display("FAIL single_pop: valid=%0b level=%0d want 0/0", ev_valid, level); end
  endtask

  task automatic test_multi_change();
    logic [15:0] es;
    int ech [3] = '{0, 1, 3};
    logic [7:0] edat [3] = '{8'h01, 8'h02, 8'h03};
    es = 16'(edges);
    tick(32'h03550201, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(32'h03550201, 1'b1, 1'b1);
      total++;
      if (ev_valid !== 1'b1 || ev_ch !== CW'(ech[k]) || ev_data !== edat[k] || ev_stamp !== es) begin bad++;
        $display("FAIL multi_ev%0d: v=%0b ch=%0d d=%0h s=%0d want 1/%0d/%0h/%0d",
                 k, ev_valid, ev_ch, ev_data, ev_stamp, ech[k], edat[k], es); end
    end
    tick(32'h03550201, 1'b1, 1'b1);
    total++; if (ev_valid !== 1'b0 || tot_cnt !== 16'd4 || tog_s !== 4'b1111) begin bad++;
      $display("FAIL multi_end: v=%0b tot=%0d tog=%0h want 0/4/f", ev_valid, tot_cnt, tog_s); end
  endtask

  // 13 changes rotating over channels with no consumer: 8 fill the FIFO,
  // 4 stay pending, the last lands on an occupied slot.
  task automatic test_fill_ovf(output logic [NCH*W-1:0] v);
    int t0;
    v = din_s; t0 = int'(tot_cnt);
    for (int k = 0; k < 13; k++) begin
      v[(k % NCH)*W +: W] = v[(k % NCH)*W +: W] + 8'd1;
      tick(v, 1'b0, 1'b1);
      total++; if (ovf !== (k == 12)) begin bad++;
        $display("FAIL fill_ovf_k%0d: got %0b want %0b", k, ovf, (k == 12)); end
    end
    tick(v, 1'b0, 1'b1); tick(v, 1'b0, 1'b1);
    total++; if (level !== 4'd8 || ev_valid !== 1'b1) begin bad++;
      $display("FAIL fill_level: level=%0d v=%0b want 8/1", level, ev_valid); end
    total++; if (int'(tot_cnt) !== t0 + 8) begin bad++;
      $display("FAIL fill_tot: got %0d want %0d", tot_cnt, t0 + 8); end
    total++; if (ev_ch !== 2'd0 || ev_data !== 8'h02) begin bad++;
      $display("FAIL fill_head: ch=%0d d=%0h want 0/02", ev_ch, ev_data); end
  endtask

  task automatic test_full_pushpop(input logic [NCH*W-1:0] v);
    int hc; logic [W-1:0] hd; logic [15:0] hs; int t0; int n;
    hc = qc[1]; hd = qd[1]; hs = qs[1]; t0 = int'(tot_cnt);
    tick(v, 1'b1, 1'b1);
    total++; if (level !== 4'd8) begin bad++;
      $display("FAIL pushpop_level: got %0d want 8", level); end
    total++; if (ev_ch !== CW'(hc) || ev_data !== hd || ev_stamp !== hs) begin bad++;
      $display("FAIL pushpop_head: ch=%0d d=%0h s=%0d want %0d/%0h/%0d", ev_ch, ev_data, ev_stamp, hc, hd, hs); end
    tick(v, 1'b0, 1'b1);
    total++; if (level !== 4'd8) begin bad++;
      $display("FAIL full_hold: got %0d want 8", level); end
    n = 0;
    while ((ev_valid || qc.size() != 0) && n < 40) begin
      total++;
      if (qc.size() == 0 || ev_ch !== CW'(qc[0]) || ev_data !== qd[0] || ev_stamp !== qs[0]) begin bad++;
        $display("FAIL drain_head: ch=%0d d=%0h s=%0d modelq=%0d", ev_ch, ev_data, ev_stamp, qc.size()); end
      tick(v, 1'b1, 1'b1);
      n++;
    end
    total++; if (n >= 40 || ev_valid !== 1'b0 || level !== '0) begin bad++;
      $display("FAIL drain_end: n=%0d v=%0b level=%0d want empty", n, ev_valid, level); end
    total++; if (int'(tot_cnt) !== t0 + 4 || ovf !== 1'b1) begin bad++;
      $display("FAIL drain_tot: tot=%0d ovf=%0b want %0d/1", tot_cnt, ovf, t0 + 4); end
  endtask

  task automatic test_reset_mid();
    logic [NCH*W-1:0] v;
    v = 32'hA0B1C2D3;
    tick(v, 1'b0, 1'b0);
    tick(v, 1'b0, 1'b1);
    v = v ^ 32'h01010101;
    tick(v, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) tick(v, 1'b0, 1'b1);
    v = v ^ 32'h02020202;
    tick(v, 1'b0, 1'b1);
    v = v ^ 32'h04000000;
    tick(v, 1'b0, 1'b1);
    total++; if (level !== 4'd5 || ovf !== 1'b1) begin bad++;
      $display("FAIL mid_pre: level=%0d ovf=%0b want 5/1", level, ovf); end
    tick(v, 1'b0, 1'b0);
    total++; if (level !== '0 || ovf !== 1'b0 || tot_cnt !== '0 || ev_valid !== 1'b0 || o_s !== '0) begin bad++;
      $display("FAIL mid_reset: level=%0d ovf=%0b tot=%0d v=%0b o=%0h want all 0", level, ovf, tot_cnt, ev_valid, o_s); end
    tick(v, 1'b1, 1'b1);
    for (int n = 0; n < 20; n++) begin
      tick(v, 1'b1, 1'b1);
      total++; if (ev_valid !== 1'b0) begin bad++;
        $display("FAIL mid_stale: cycle %0d valid=%0b want 0", n, ev_valid); end
    end
    total++; if (tot_cnt !== '0 || o_s !== v || tog_s !== '0) begin bad++;
      $display("FAIL mid_after: tot=%0d o=%0h tog=%0h want 0/%0h/0", tot_cnt, o_s, tog_s, v); end
  endtask

  task automatic test_random();
    logic [NCH*W-1:0] v, eo;
    logic rdy, rn;
    int bias;
    v = NCH*W'($urandom);
    tick(v, 1'b0, 1'b0);
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) v[c*W +: W] = W'($urandom);
      bias = ((n / 75) % 2 == 0) ? 1 : 3;
      rdy = (int'($urandom_range(0, 3)) < bias);
      rn  = ($urandom_range(0, 249) != 0);
      tick(v, rdy, rn);
      for (int c = 0; c < NCH; c++) eo[c*W +: W] = m_o[c];
      total++; if (o_s !== eo || tog_s !== m_tog) begin bad++;
        $display("FAIL rnd_o_tog @%0d: o=%0h tog=%0h want %0h/%0h", n, o_s, tog_s, eo, m_tog); end
      total++; if (level !== LW'(qc.size()) || ev_valid !== (qc.size() != 0)) begin bad++;
        $display("FAIL rnd_level @%0d: level=%0d v=%0b want %0d", n, level, ev_valid, qc.size()); end
      total++; if (ovf !== m_ovf || tot_cnt !== m_tot) begin bad++;
        $display("FAIL rnd_flags @%0d: ovf=%0b tot=%0d want %0b/%0d", n, ovf, tot_cnt, m_ovf, m_tot); end
      if (qc.size() != 0) begin
        total++;
        if (ev_ch !== CW'(qc[0]) || ev_data !== qd[0] || ev_stamp !== qs[0]) begin bad++;
          $display("FAIL rnd_head @%0d: ch=%0d d=%0h s=%0d want %0d/%0h/%0d",
                   n, ev_ch, ev_data, ev_stamp, qc[0], qd[0], qs[0]); end
      end
    end
  endtask

  initial begin
    logic [NCH*W-1:0] vf;
    test_reset();
    test_single_change();
    test_multi_change();
    test_fill_ovf(vf);
    test_full_pushpop(vf);
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
